// File: rtl/led_ctrl_pkg.sv
// Shared types and default widths for the LED pattern controller.
package led_ctrl_pkg;

    typedef enum logic [1:0] {MODE_OFF, MODE_SOLID, MODE_BLINK, MODE_BURST} mode_t;
    typedef enum logic [1:0] {S_IDLE, S_SOLID, S_BLINK, S_BURST} state_t;

    localparam int HP_W_DEF  = 24;
    localparam int CNT_W_DEF = 4;

endpackage

// File: rtl/phase_timer.sv
// Phase counter: counts 0..hp while enabled and flags the last cycle of each phase.
module phase_timer
    import led_ctrl_pkg::*;
#(
    parameter int HP_W = HP_W_DEF
) (
    input  logic            clk,
    input  logic            nreset,
    input  logic            load,
    input  logic            en,
    input  logic [HP_W-1:0] hp,
    output logic            tick
);

    logic [HP_W-1:0] cnt;

    // Equality compare means cnt never passes hp, so no wrap handling is needed.
    assign tick = en && (cnt == hp);

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset)   cnt <= '0;
        else if (load) cnt <= '0;
        else if (tick) cnt <= '0;
        else if (en)   cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/led_pattern_ctrl.sv
// Handshaked LED sequencer: off, solid, continuous blink and N-pulse burst with done pulse.
module led_pattern_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int HP_W  = HP_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [1:0]       cfg_mode,
    input  logic [HP_W-1:0]  cfg_half_period,
    input  logic [CNT_W-1:0] cfg_count,
    output logic             led,
    output logic             busy,
    output logic             done
);

    state_t           state, state_d;
    logic             led_d, done_d;
    logic [HP_W-1:0]  hp_q, hp_d;
    logic [CNT_W-1:0] n_q, n_d, pcnt, pcnt_d;
    logic             accept, tick, timer_en;

    assign cfg_ready = (state != S_BURST);
    assign busy      = (state == S_BLINK) || (state == S_BURST);
    assign accept    = cfg_valid && cfg_ready;
    assign timer_en  = busy;

    phase_timer #(.HP_W(HP_W)) u_timer (
        .clk    (clk),
        .nreset (nreset),
        .load   (accept),
        .en     (timer_en),
        .hp     (hp_q),
        .tick   (tick)
    );

    always_comb begin
        state_d = state;
        led_d   = led;
        done_d  = 1'b0;
        pcnt_d  = pcnt;
        hp_d    = hp_q;
        n_d     = n_q;
        if (accept) begin
            // A new config always restarts from a clean phase, whatever was running.
            hp_d   = cfg_half_period;
            n_d    = cfg_count;
            pcnt_d = '0;
            case (mode_t'(cfg_mode))
                MODE_OFF:   begin state_d = S_IDLE;  led_d = 1'b0; end
                MODE_SOLID: begin state_d = S_SOLID; led_d = 1'b1; end
                MODE_BLINK: begin state_d = S_BLINK; led_d = 1'b1; end
                default: begin
                    if (cfg_count == '0) begin
                        state_d = S_IDLE;
                        led_d   = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_BURST;
                        led_d   = 1'b1;
                    end
                end
            endcase
        end else begin
            case (state)
                S_BLINK: if (tick) led_d = ~led;
                S_BURST: begin
                    if (tick) begin
                        if (led) begin
                            led_d  = 1'b0;
                            pcnt_d = pcnt + 1'b1;
                        end else if (pcnt == n_q) begin
                            // Final low phase over: burst finished.
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end else begin
                            led_d = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state <= S_IDLE;
            led   <= 1'b0;
            done  <= 1'b0;
            pcnt  <= '0;
            hp_q  <= '0;
            n_q   <= '0;
        end else begin
            state <= state_d;
            led   <= led_d;
            done  <= done_d;
            pcnt  <= pcnt_d;
            hp_q  <= hp_d;
            n_q   <= n_d;
        end
    end

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Directed bench for led_pattern_ctrl: vector table plus hand-written burst/reset sequences.
module tb_led_pattern_ctrl;
    import led_ctrl_pkg::*;

    localparam int HP_W  = 24;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             nreset;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [1:0]       cfg_mode;
    logic [HP_W-1:0]  cfg_half_period;
    logic [CNT_W-1:0] cfg_count;
    logic             led, busy, done;

    int tests = 0;
    int fails = 0;

    led_pattern_ctrl #(.HP_W(HP_W), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .nreset          (nreset),
        .cfg_valid       (cfg_valid),
        .cfg_ready       (cfg_ready),
        .cfg_mode        (cfg_mode),
        .cfg_half_period (cfg_half_period),
        .cfg_count       (cfg_count),
        .led             (led),
        .busy            (busy),
        .done            (done)
    );

    always #5 clk = ~clk;

    // Inputs applied for one cycle, and {led,busy,done,cfg_ready} expected after the edge.
    typedef struct {
        logic             valid;
        logic [1:0]       mode;
        logic [HP_W-1:0]  hp;
        logic [CNT_W-1:0] cnt;
        logic [3:0]       exp;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic v, input logic [1:0] m, input logic [HP_W-1:0] h,
                       input logic [CNT_W-1:0] c, input logic [3:0] e);
        vec_t x;
        x.valid = v; x.mode = m; x.hp = h; x.cnt = c; x.exp = e;
        vecs.push_back(x);
    endtask

    task automatic chk(input string name, input logic [3:0] exp);
        logic [3:0] act;
        act = {led, busy, done, cfg_ready};
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: {led,busy,done,ready} got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] m, input logic [HP_W-1:0] h,
                         input logic [CNT_W-1:0] c);
        cfg_valid = v; cfg_mode = m; cfg_half_period = h; cfg_count = c;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int k;
        logic seen;
        nreset = 1'b0;
        drive(1'b0, 2'd0, '0, '0);
        #12;
        chk("reset_state", 4'b0001);
        @(negedge clk);
        nreset = 1'b1;
        step();

        // {led,busy,done,ready}
        add(0, MODE_OFF,   0, 0, 4'b0001);               // idle
        add(1, MODE_BLINK, 3, 0, 4'b1101);               // blink H=3: t+1
        for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 4'b1101); // t+2..t+4
        for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 4'b0101); // t+5..t+8
        add(0, 0, 0, 0, 4'b1101);                        // t+9
        add(1, MODE_OFF,   0, 0, 4'b0001);               // off
        add(1, MODE_BURST, 0, 0, 4'b0011);               // burst N=0: done at t+1
        add(0, 0, 0, 0, 4'b0001);
        add(1, MODE_BLINK, 5, 0, 4'b1101);               // blink H=5
        for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 4'b1101);
        add(1, MODE_SOLID, 0, 0, 4'b1001);               // solid accepted at t+4
        for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 4'b1001);
        add(1, MODE_BLINK, 0, 0, 4'b1101);               // blink H=0
        add(0, 0, 0, 0, 4'b0101);
        add(0, 0, 0, 0, 4'b1101);
        add(0, 0, 0, 0, 4'b0101);
        add(0, 0, 0, 0, 4'b1101);
        add(1, MODE_OFF,   0, 0, 4'b0001);
        add(1, MODE_BLINK, 1, 0, 4'b1101);               // valid held: last one wins
        add(1, MODE_SOLID, 0, 0, 4'b1001);
        add(1, MODE_BLINK, {HP_W{1'b1}}, 0, 4'b1101);    // max half period
        for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 4'b1101);
        add(1, MODE_OFF,   0, 0, 4'b0001);
        add(0, 0, 0, 0, 4'b0001);

        foreach (vecs[i]) begin
            drive(vecs[i].valid, vecs[i].mode, vecs[i].hp, vecs[i].cnt);
            step();
            chk($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Burst H=2 N=3 with an ignored config attempt at t+5.
        drive(1, MODE_BURST, 2, 3);
        step();
        for (k = 1; k <= 18; k++) begin
            chk($sformatf("burst_t%0d", k), {(((k - 1) / 3) % 2 == 0), 1'b1, 1'b0, 1'b0});
            if (k == 5) drive(1, MODE_SOLID, 0, 0);
            else        drive(0, MODE_OFF, 0, 0);
            step();
        end
        chk("burst_done", 4'b0011);
        step();
        chk("burst_after", 4'b0001);

        // Max pulse count N=15, H=0: done expected at t+31.
        drive(1, MODE_BURST, 0, 15);
        step();
        drive(0, MODE_OFF, 0, 0);
        seen = 1'b0;
        for (k = 1; k <= 40 && !seen; k++) begin
            if (done) seen = 1'b1;
            else step();
        end
        tests++;
        if (!seen || k - 1 != 31) begin
            fails++;
            $display("FAIL burst15_done_cycle: got %0d expected 31 (seen=%0b)", k - 1, seen);
        end

        // Async reset mid-blink and mid-burst.
        drive(1, MODE_BLINK, 3, 0);
        step();
        drive(0, MODE_OFF, 0, 0);
        step();
        chk("pre_reset_blink", 4'b1101);
        #2 nreset = 1'b0;
        #1 chk("async_reset_blink", 4'b0001);
        @(negedge clk);
        nreset = 1'b1;
        drive(1, MODE_BURST, 1, 2);
        step();
        drive(0, MODE_OFF, 0, 0);
        step();
        chk("pre_reset_burst", 4'b1100);
        #2 nreset = 1'b0;
        #1 chk("async_reset_burst", 4'b0001);
        @(negedge clk);
        nreset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("no_done_after_reset", 4'b0001);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
